fifo_uart_hex_tx: RTL and testbench

// - Downstream drain stage for the LFSR->FIFO path: pops 4-bit entries from the FIFO and sends each as one

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/fifo_uart_hex_tx.sv | 160 ++++++++++++++++
 tb/tb_fifo_uart_hex_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-to-UART hex drain stage.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    WAIT_DATA,
    START,
    DATA,
    PARITY,
    STOP,
    LINEBRK
  } tx_state_e;

  typedef enum logic [1:0] {
    K_HEX,
    K_CR,
    K_LF
  } char_kind_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
    logic [7:0] w;
    w = {4'h0, n};
    return (n < 4'd10) ? (8'h30 + w) : (8'h37 + w);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick on the last cycle of every CLKS_PER_BIT window.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic ONE_CLK = (CLKS_PER_BIT == 1);

  logic [CW-1:0] cnt;

  // clear marks the first cycle of a state, where the count is taken as 0
  assign tick = clear ? ONE_CLK : (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= ONE_CLK ? '0 : CW'(1);
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_hex_tx.sv
// Drains 4-bit FIFO entries to a UART line as ASCII hex, with CR/LF rows.
// Define UART_TX_PARITY_EN for an even-parity (8E1) frame.
import uart_pkg::*;

module fifo_uart_hex_tx #(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int BAUD_RATE      = 115200,
  parameter int DATA_WIDTH     = 4,
  parameter int CHARS_PER_LINE = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_data_valid,
  output logic                  fifo_pop,
  output logic                  uart_tx,
  output logic                  busy,
  output logic                  char_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int LW = (CHARS_PER_LINE > 1) ? $clog2(CHARS_PER_LINE) : 1;
  localparam logic [LW-1:0] LINE_LAST = LW'(CHARS_PER_LINE - 1);

  tx_state_e  state;
  char_kind_e kind;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [1:0]    wait_cnt;
  logic [LW-1:0] line_cnt;
  logic          clr;
  logic          tick;
  logic [7:0]    hex_char;
  logic [7:0]    brk_char;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (clr),
    .tick   (tick)
  );

  assign hex_char  = hex_to_ascii(fifo_data[3:0]);
  assign brk_char  = (kind == K_CR) ? ASCII_CR : ASCII_LF;
  assign busy      = (state != IDLE);
  assign char_done = (state == STOP) && tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      kind     <= K_HEX;
      shift    <= '0;
      bit_idx  <= '0;
      wait_cnt <= '0;
      line_cnt <= '0;
      clr      <= 1'b0;
      fifo_pop <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      clr      <= 1'b0;
      fifo_pop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable && !fifo_empty) begin
            state    <= POP;
            fifo_pop <= 1'b1;
            clr      <= 1'b1;
          end
        end
        POP: begin
          state    <= WAIT_DATA;
          wait_cnt <= '0;
          clr      <= 1'b1;
        end
        WAIT_DATA: begin
          if (fifo_data_valid) begin
            shift   <= hex_char;
            kind    <= K_HEX;
            uart_tx <= 1'b0;
            state   <= START;
            clr     <= 1'b1;
          end else if (wait_cnt == 2'd3) begin
            state <= IDLE;
            clr   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        START: begin
          if (tick) begin
            bit_idx <= '0;
            uart_tx <= shift[0];
            state   <= DATA;
            clr     <= 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              // rotation keeps the XOR of the byte intact
              uart_tx <= ^shift;
              state   <= PARITY;
`else
              uart_tx <= 1'b1;
              state   <= STOP;
`endif
              clr <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {shift[0], shift[7:1]};
              uart_tx <= shift[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            uart_tx <= 1'b1;
            state   <= STOP;
            clr     <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            clr   <= 1'b1;
            state <= IDLE;
            unique case (kind)
              K_HEX: begin
                if (line_cnt == LINE_LAST) begin
                  line_cnt <= '0;
                  kind     <= K_CR;
                  state    <= LINEBRK;
                end else begin
                  line_cnt <= line_cnt + LW'(1);
                end
              end
              K_CR: begin
                kind  <= K_LF;
                state <= LINEBRK;
              end
              default: kind <= K_HEX;
            endcase
          end
        end
        LINEBRK: begin
          shift   <= brk_char;
          uart_tx <= 1'b0;
          state   <= START;
          clr     <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_hex_tx.sv
// Directed bench for fifo_uart_hex_tx: FIFO model, UART line decoder, checks.
// Runs at 16 clocks per bit to keep the run short.
module tb_fifo_uart_hex_tx;

  localparam int CLKS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11 * CLKS;
`else
  localparam int FL = 10 * CLKS;
`endif

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       fifo_empty;
  logic [3:0] fifo_data;
  logic       fifo_data_valid;
  logic       fifo_pop;
  logic       uart_tx;
  logic       busy;
  logic       char_done;

  fifo_uart_hex_tx #(
    .CLK_FREQ_HZ   (1_000_000),
    .BAUD_RATE     (62_500),
    .DATA_WIDTH    (4),
    .CHARS_PER_LINE(16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_data      (fifo_data),
    .fifo_data_valid(fifo_data_valid),
    .fifo_pop       (fifo_pop),
    .uart_tx        (uart_tx),
    .busy           (busy),
    .char_done      (char_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pops = 0;
  int dones = 0;
  bit drop = 0;
  bit pend = 0;
  logic [3:0] q[$];
  logic [3:0] held;
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic       rx_p[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // FIFO with one cycle of read latency: valid follows the pop cycle
  initial begin
    fifo_data = '0;
    fifo_data_valid = 1'b0;
    fifo_empty = 1'b1;
  end

  always @(negedge clk) begin
    fifo_data_valid = 1'b0;
    if (pend) begin
      pend = 0;
      if (!drop) begin
        fifo_data = held;
        fifo_data_valid = 1'b1;
      end
    end
    if (fifo_pop === 1'b1) begin
      pops++;
      if (q.size() > 0) begin
        held = q.pop_front();
        pend = 1;
      end
    end
    if (char_done === 1'b1) dones++;
    fifo_empty = (q.size() == 0);
  end

  // UART line decoder; frames cut by reset are discarded
  always begin : mon
    logic [7:0] b;
    logic       p;
    logic       bad;
    int         t0;
    @(negedge uart_tx);
    t0 = cyc;
    bad = !reset_n;
    b = '0;
    p = 1'b0;
    repeat (CLKS / 2) begin
      @(negedge clk);
      if (!reset_n) bad = 1;
    end
    if (uart_tx !== 1'b0) bad = 1;
    for (int i = 0; i < 8; i++) begin
      repeat (CLKS) begin
        @(negedge clk);
        if (!reset_n) bad = 1;
      end
      b[i] = uart_tx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (CLKS) begin
      @(negedge clk);
      if (!reset_n) bad = 1;
    end
    p = uart_tx;
`endif
    repeat (CLKS) begin
      @(negedge clk);
      if (!reset_n) bad = 1;
    end
    if (uart_tx !== 1'b1) bad = 1;
    if (!bad) begin
      rx_q.push_back(b);
      rx_t.push_back(t0);
      rx_p.push_back(p);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] v);
    q.push_back(v);
  endtask

  task automatic rx_clear();
    rx_q.delete();
    rx_t.delete();
    rx_p.delete();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("rx_count", rx_q.size(), n);
    repeat (30) @(negedge clk);
  endtask

  task automatic wait_tx(input logic lvl, output int t);
    int k = 0;
    while (uart_tx !== lvl && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("tx_level_seen", uart_tx, lvl);
    t = cyc;
  endtask

  initial begin : stim
    string hex = "0123456789ABCDEF";
    int bad_tx, bad_busy, p0, d0, ta, tb, d;

    reset_n = 1'b1;
    enable = 1'b0;
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_pop", fifo_pop, 0);
    chk("rst_char_done", char_done, 0);
    reset_n = 1'b1;
    enable = 1'b1;

    bad_tx = 0;
    bad_busy = 0;
    repeat (5000) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("idle_pops", pops, 0);
    chk("idle_tx_low", bad_tx, 0);
    chk("idle_busy", bad_busy, 0);

    rx_clear();
    d0 = dones;
    push(4'hA);
    wait_tx(1'b0, ta);
    wait_tx(1'b1, tb);
    chk("bit_period", tb - ta, CLKS);
    wait_rx(1, 3000);
    chk("char_A", rx_q[0], 8'h41);
    chk("pops_A", pops, 1);
    chk("done_A", dones - d0, 1);
    chk("busy_after_A", busy, 0);

    rx_clear();
    push(4'h3);
    push(4'hF);
    wait_rx(2, 3000);
    chk("char_3", rx_q[0], 8'h33);
    chk("char_F", rx_q[1], 8'h46);
    chk("pops_3F", pops, 3);
    d = rx_t[1] - rx_t[0];
    chk("frame_gap", (d >= FL && d <= FL + 5), 1);

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rx_clear();
    for (int i = 0; i < 17; i++) push(4'(i));
    wait_rx(19, 8000);
    for (int i = 0; i < 16; i++)
      chk($sformatf("line_char%0d", i), rx_q[i], {24'h0, hex[i]});
    chk("line_cr", rx_q[16], 8'h0D);
    chk("line_lf", rx_q[17], 8'h0A);
    chk("line_next", rx_q[18], 8'h30);

    rx_clear();
    for (int i = 0; i < 15; i++) push(4'h9);
    wait_rx(17, 8000);
    chk("row2_char14", rx_q[14], 8'h39);
    chk("row2_cr", rx_q[15], 8'h0D);
    chk("row2_lf", rx_q[16], 8'h0A);

    rx_clear();
    push(4'h1);
    push(4'h2);
    push(4'h3);
    wait_rx(3, 3000);
    push(4'h5);
    wait_tx(1'b0, ta);
    repeat (CLKS + 3 * CLKS + CLKS / 2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_tx", uart_tx, 1);
    chk("rst_mid_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    rx_clear();
    for (int i = 0; i < 16; i++) push(4'hC);
    wait_rx(18, 8000);
    chk("post_rst_char0", rx_q[0], 8'h43);
    chk("post_rst_char15", rx_q[15], 8'h43);
    chk("post_rst_cr", rx_q[16], 8'h0D);
    chk("post_rst_lf", rx_q[17], 8'h0A);

    rx_clear();
    p0 = pops;
    drop = 1;
    push(4'hE);
    repeat (30) @(negedge clk);
    drop = 0;
    chk("timeout_pops", pops - p0, 1);
    chk("timeout_rx", rx_q.size(), 0);
    chk("timeout_busy", busy, 0);

    rx_clear();
    p0 = pops;
    push(4'h1);
    push(4'h2);
    wait_tx(1'b0, ta);
    enable = 1'b0;
    repeat (3 * FL) @(negedge clk);
    chk("dis_rx", rx_q.size(), 1);
    chk("dis_char", rx_q[0], 8'h31);
    chk("dis_pops", pops - p0, 1);
    chk("dis_busy", busy, 0);
    enable = 1'b1;
    wait_rx(2, 3000);
    chk("en_char", rx_q[1], 8'h32);

`ifdef UART_TX_PARITY_EN
    rx_clear();
    push(4'h7);
    wait_rx(1, 3000);
    chk("par_char", rx_q[0], 8'h37);
    chk("par_bit", rx_p[0], 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
